// File: rtl/uart_rx_frontend_if.sv
// Receive-side byte bus from the UART deframer toward the CDC/FIFO stage.
// master drives the decoded byte and status pulses; slave observes them.
interface uart_rx_frontend_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (output rx_data, output rx_valid, output frame_err, output busy);
  modport slave  (input  rx_data, input  rx_valid, input  frame_err, input  busy);
endinterface

// File: rtl/uart_rx_frontend.sv
// 8N1 UART receiver: synchronizes rxd, samples mid-bit with a per-bit counter and
// emits one-cycle rx_valid (good stop) or frame_err (low stop) pulses.
module uart_rx_frontend #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic                clk_rx,
  input  logic                rst,
  input  logic                rxd,
  uart_rx_frontend_if.master  rx
);
  localparam int unsigned HALF = CLKS_PER_BIT >> 1;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);

  localparam logic [2:0] WAIT_IDLE = 3'd0;
  localparam logic [2:0] IDLE      = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] DATA      = 3'd3;
  localparam logic [2:0] STOP      = 3'd4;

  logic          rxd_m, rxd_s;
  logic [2:0]    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    sh, sh_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          valid_q, valid_nxt;
  logic          err_q, err_nxt;
  logic          busy_q, busy_nxt;

  // Two-flop synchronizer; resets low so WAIT_IDLE must see a real high before arming.
  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      rxd_m <= 1'b0;
      rxd_s <= 1'b0;
    end else begin
      rxd_m <= rxd;
      rxd_s <= rxd_m;
    end
  end

  always_ff @(posedge clk_rx or posedge rst) begin
    if (rst) begin
      state   <= WAIT_IDLE;
      cnt     <= '0;
      idx     <= '0;
      sh      <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      sh      <= sh_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
      busy_q  <= busy_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sh_nxt    = sh;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      WAIT_IDLE: begin
        if (rxd_s) state_nxt = IDLE;
      end
      IDLE: begin
        if (!rxd_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        // Mid-start-bit check: a line already back high was only a glitch.
        if (cnt == CW'(HALF - 1)) begin
          cnt_nxt = '0;
          if (!rxd_s) begin
            state_nxt = DATA;
            idx_nxt   = '0;
          end else begin
            state_nxt = IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          sh_nxt[idx] = rxd_s;
          cnt_nxt     = '0;
          idx_nxt     = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == CW'(CLKS_PER_BIT - 1)) begin
          cnt_nxt = '0;
          if (rxd_s) begin
            data_nxt  = sh;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      default: state_nxt = WAIT_IDLE;
    endcase

    busy_nxt = (state_nxt == START) || (state_nxt == DATA) || (state_nxt == STOP);
  end

  assign rx.rx_data   = data_q;
  assign rx.rx_valid  = valid_q;
  assign rx.frame_err = err_q;
  assign rx.busy      = busy_q;
endmodule
